// File: rtl/seg7_scan.sv
// Four-digit common-anode 7-segment scanner for the HH.MM / MM.SS clock display,
// with leading-zero hour blanking and blinking of the field under adjustment.
module seg7_scan #(
  parameter int unsigned SCAN_DIV    = 12500,
  parameter int unsigned BLINK_SCANS = 1000
) (
  input  logic       clk,
  input  logic       cr,
  input  logic [3:0] bcd_su,
  input  logic [3:0] bcd_st,
  input  logic [3:0] bcd_mu,
  input  logic [3:0] bcd_mt,
  input  logic [3:0] bcd_hu,
  input  logic [3:0] bcd_ht,
  input  logic       page,
  input  logic       adjust,
  input  logic       min_hour,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned DW = (SCAN_DIV    > 1) ? $clog2(SCAN_DIV)    : 1;
  localparam int unsigned BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  logic [DW-1:0] r_div_cnt;
  logic [1:0]    r_idx;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_ph;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic          w_tick;
  logic          w_blink_wrap;
  logic [1:0]    w_idx_nxt;
  logic [3:0]    w_digit;
  logic [6:0]    w_dec;
  logic          w_lead_blank;
  logic          w_blink_blank;
  logic [6:0]    w_seg_nxt;

  assign w_tick       = (r_div_cnt == DW'(SCAN_DIV - 1));
  assign w_blink_wrap = (r_blink_cnt == BW'(BLINK_SCANS - 1));
  assign w_idx_nxt    = 2'(r_idx + 2'd1);

  // Everything below selects for the slot about to start, so it is latched on the tick.
  always_comb begin
    w_digit = '0;
    unique case ({page, w_idx_nxt})
      3'b0_00: w_digit = bcd_mu;
      3'b0_01: w_digit = bcd_mt;
      3'b0_10: w_digit = bcd_hu;
      3'b0_11: w_digit = bcd_ht;
      3'b1_00: w_digit = bcd_su;
      3'b1_01: w_digit = bcd_st;
      3'b1_10: w_digit = bcd_mu;
      3'b1_11: w_digit = bcd_mt;
      default: w_digit = '0;
    endcase
  end

  always_comb begin
    w_dec = 7'b0111111;
    case (w_digit)
      4'd0: w_dec = 7'b1000000;
      4'd1: w_dec = 7'b1111001;
      4'd2: w_dec = 7'b0100100;
      4'd3: w_dec = 7'b0110000;
      4'd4: w_dec = 7'b0011001;
      4'd5: w_dec = 7'b0010010;
      4'd6: w_dec = 7'b0000010;
      4'd7: w_dec = 7'b1111000;
      4'd8: w_dec = 7'b0000000;
      4'd9: w_dec = 7'b0010000;
      default: w_dec = 7'b0111111;
    endcase
  end

  always_comb begin
    w_lead_blank  = !page && (w_idx_nxt == 2'd3) && (bcd_ht == 4'd0);
    w_blink_blank = 1'b0;
    if (adjust && r_blink_ph) begin
      if (min_hour) w_blink_blank = page ? w_idx_nxt[1] : !w_idx_nxt[1];
      else          w_blink_blank = !page && w_idx_nxt[1];
    end
    w_seg_nxt = (w_blink_blank || w_lead_blank) ? '1 : w_dec;
  end

  always_ff @(posedge clk) begin
    if (cr) begin
      r_div_cnt   <= '0;
      r_idx       <= '0;
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
      r_an        <= '1;
      r_seg       <= '1;
      r_dp        <= 1'b1;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_idx     <= w_idx_nxt;
      r_an      <= ~(4'b0001 << w_idx_nxt);
      r_seg     <= w_seg_nxt;
      r_dp      <= (w_idx_nxt != 2'd2);
      if (w_blink_wrap) begin
        r_blink_cnt <= '0;
        r_blink_ph  <= ~r_blink_ph;
      end else begin
        r_blink_cnt <= BW'(r_blink_cnt + 1'b1);
      end
    end else begin
      r_div_cnt <= DW'(r_div_cnt + 1'b1);
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule
